ofm_wb: RTL and testbench

OFM_WB -- requirements
Module: ofm_wb

---
 rtl/ofm_wb.sv | 118 +++++++++++
 tb/tb_ofm_wb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_wb.sv
// OFM write-back: packs accepted OFM bytes into 32-bit words and writes them to memory with a valid/ack handshake.
// Optional ReLU on packed bytes is enabled by defining OFM_WB_RELU_EN.
module ofm_wb #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bytes,
    input  logic              ofm_valid,
    input  logic [7:0]        ofm_data,
    output logic              ofm_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] remaining;
    logic [7:0]       packed_byte;

    // Handshakes: a byte moves when ofm_valid && ofm_ready at a rising edge;
    // a write completes when mem_wr_en && mem_ack at a rising edge.
`ifdef OFM_WB_RELU_EN
    assign packed_byte = ofm_data[7] ? 8'h00 : ofm_data;
`else
    assign packed_byte = ofm_data;
`endif

    assign dbg_state = state;

    // All outputs are registered alongside the state so they change in step with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            remaining <= '0;
            ofm_ready <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= base_addr;
                        remaining <= num_bytes;
                        byte_idx  <= 2'd0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        busy      <= 1'b1;
                        if (num_bytes == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= COLLECT;
                            ofm_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (ofm_valid) begin
                        mem_wdata[byte_idx*8 +: 8] <= packed_byte;
                        mem_be[byte_idx]           <= 1'b1;
                        byte_idx                   <= byte_idx + 2'd1;
                        remaining                  <= remaining - 1'b1;
                        if (byte_idx == 2'd3 || remaining == 1) begin
                            state     <= WRITE;
                            ofm_ready <= 1'b0;
                            mem_wr_en <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_wr_en <= 1'b0;
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        byte_idx  <= 2'd0;
                        if (remaining == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= COLLECT;
                            ofm_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_wb.sv
// Self-checking bench for ofm_wb: scoreboarded memory writes, stall stability, zero-length, wrap and reset-abort jobs.
// Define OFM_WB_RELU_EN for both RTL and bench to exercise the ReLU build.
module tb_ofm_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] num_bytes = '0;
    logic        ofm_valid = 1'b0;
    logic [7:0]  ofm_data = '0;
    logic        ofm_ready;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {addr, be, wdata}
    logic [51:0] exp_q[$];
    logic [7:0]  job_b[16];
    int          ack_delay = 0;
    logic        hold_ack = 1'b0;

    ofm_wb #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_bytes(num_bytes), .ofm_valid(ofm_valid), .ofm_data(ofm_data),
        .ofm_ready(ofm_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef OFM_WB_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    // Memory side: acks after ack_delay stall cycles, checks stability and scoreboard.
    logic        in_write = 1'b0;
    logic [51:0] held;
    int          wait_cnt = 0;
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (in_write) check("wr_stable", {12'h0, mem_addr, mem_be, mem_wdata}, {12'h0, held});
            else held = {mem_addr, mem_be, mem_wdata};
            in_write = 1'b1;
            check("ready_in_write", {63'h0, ofm_ready}, 64'h0);
            if (!mem_ack && !hold_ack) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {12'h0, mem_addr, mem_be, mem_wdata}, 64'h0);
                    end else begin
                        check("write", {12'h0, mem_addr, mem_be, mem_wdata}, {12'h0, exp_q.pop_front()});
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end else begin
            in_write = 1'b0;
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic push_expected(input logic [15:0] base, input int n);
        logic [15:0] a;
        logic [31:0] w;
        logic [3:0]  be;
        a = base; w = '0; be = '0;
        for (int j = 0; j < n; j++) begin
            w[(j%4)*8 +: 8] = relu(job_b[j]);
            be[j%4] = 1'b1;
            if (j % 4 == 3 || j == n - 1) begin
                exp_q.push_back({a, be, w});
                a = a + 16'd1; w = '0; be = '0;
            end
        end
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [15:0] n);
        @(negedge clk);
        base_addr = base; num_bytes = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_bytes(input int n, input bit stalls);
        int  i = 0;
        int  guard = 0;
        logic rdy;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            ofm_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            ofm_data  = job_b[i];
            rdy = ofm_ready && ofm_valid;
            @(posedge clk);
            if (rdy) i++;
            guard++;
        end
        if (guard >= 2000) check("feed_timeout", 64'(i), 64'(n));
        @(negedge clk);
        ofm_valid = 1'b0;
    endtask

    task automatic wait_done();
        int saw = 0;
        int k = 0;
        while (saw == 0 && k < 500) begin
            @(negedge clk);
            if (done) saw = 1;
            k++;
        end
        check("done_seen", 64'(saw), 64'd1);
        @(negedge clk);
        check("done_one_cycle", {63'h0, done}, 64'h0);
        check("idle_busy", {63'h0, busy}, 64'h0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_job(input logic [15:0] base, input int n, input int dly, input bit stalls);
        ack_delay = dly;
        push_expected(base, n);
        pulse_start(base, 16'(n));
        check("busy_after_start", {63'h0, busy}, 64'h1);
        feed_bytes(n, stalls);
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", {63'h0, ofm_ready}, 64'h0);
        check("rst_wr_en", {63'h0, mem_wr_en}, 64'h0);
        check("rst_addr",  {48'h0, mem_addr}, 64'h0);
        check("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        check("rst_be",    {60'h0, mem_be}, 64'h0);
        check("rst_busy",  {63'h0, busy}, 64'h0);
        check("rst_done",  {63'h0, done}, 64'h0);
        check("rst_state", {62'h0, dbg_state}, 64'h0);
        rst_n = 1'b1;

        // Directed: full word, no stalls.
        job_b[0] = 8'h01; job_b[1] = 8'h02; job_b[2] = 8'h03; job_b[3] = 8'h04;
        run_job(16'h0010, 4, 0, 1'b0);

        // Six bytes, 3-cycle ack stall, partial last word.
        for (int j = 0; j < 6; j++) job_b[j] = 8'h11 + 8'(j);
        run_job(16'h0200, 6, 3, 1'b0);

        // Address wrap.
        for (int j = 0; j < 8; j++) job_b[j] = 8'(j * 7 + 1);
        run_job(16'hFFFF, 8, 1, 1'b0);

        // Sign handling with the fixed expected word for each build.
        job_b[0] = 8'h80; job_b[1] = 8'h7F; job_b[2] = 8'hFF; job_b[3] = 8'h01;
        ack_delay = 0;
`ifdef OFM_WB_RELU_EN
        exp_q.push_back({16'h0300, 4'b1111, 32'h01007F00});
`else
        exp_q.push_back({16'h0300, 4'b1111, 32'h01FF7F80});
`endif
        pulse_start(16'h0300, 16'd4);
        feed_bytes(4, 1'b0);
        wait_done();

        // Zero-length job: done right after the start edge, no writes.
        pulse_start(16'h0400, 16'd0);
        check("zero_done", {63'h0, done}, 64'h1);
        check("zero_no_write", {63'h0, mem_wr_en}, 64'h0);
        @(negedge clk);
        check("zero_done_clear", {63'h0, done}, 64'h0);
        check("zero_idle", {63'h0, busy}, 64'h0);

        // Random jobs with random stalls.
        for (int t = 0; t < 5; t++) begin
            int n;
            n = $urandom_range(1, 13);
            for (int j = 0; j < n; j++) job_b[j] = 8'($urandom_range(0, 255));
            run_job(16'($urandom_range(0, 65535)), n, $urandom_range(0, 4), 1'b1);
        end

        // Reset while waiting in WRITE, with a second start issued mid-job.
        hold_ack = 1'b1;
        for (int j = 0; j < 8; j++) job_b[j] = 8'h21 + 8'(j);
        pulse_start(16'h0500, 16'd8);
        feed_bytes(4, 1'b0);
        check("abort_in_write", {63'h0, mem_wr_en}, 64'h1);
        pulse_start(16'h0600, 16'd4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_en", {63'h0, mem_wr_en}, 64'h0);
        check("abort_addr",  {48'h0, mem_addr}, 64'h0);
        check("abort_wdata", {32'h0, mem_wdata}, 64'h0);
        check("abort_be",    {60'h0, mem_be}, 64'h0);
        check("abort_busy",  {63'h0, busy}, 64'h0);
        check("abort_state", {62'h0, dbg_state}, 64'h0);
        @(negedge clk);
        hold_ack = 1'b0;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (mem_wr_en || done || busy || ofm_ready) seen++;
            end
            check("abort_quiet", 64'(seen), 64'd0);
        end
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
